// File: rtl/timer_bank.sv
// Bank of NUM_CH independent down-counting timers behind one memory-mapped slave port.
// Each channel has CTRL/PRESET/COUNT words, one-shot or auto-reload mode and a sticky W1C interrupt.
module timer_bank #(
    parameter int          NUM_CH    = 2,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       PrAddr,
    input  logic [31:0]       PrWD,
    input  logic              PrWe,
    input  logic [3:0]        PrBE,
    output logic [31:0]       PrRD,
    output logic              Hit,
    output logic [NUM_CH-1:0] IRQ
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    logic [31:0] w_offset;
    logic [2:0]  w_chSel;
    logic [1:0]  w_wordSel;
    logic [31:0] w_rdCtrl   [NUM_CH];
    logic [31:0] w_rdPreset [NUM_CH];
    logic [31:0] w_rdCount  [NUM_CH];

    // Channel base is word aligned, so the low address bits never change the decode.
    assign w_offset  = PrAddr - {BASE_ADDR[31:2], 2'b00};
    assign Hit       = (w_offset < 32'(16 * NUM_CH));
    assign w_chSel   = w_offset[6:4];
    assign w_wordSel = w_offset[3:2];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        state_t           r_state;
        state_t           w_stateNext;
        logic             r_en;
        logic             r_mode;
        logic             r_im;
        logic             r_pend;
        logic [CNT_W-1:0] r_preset;
        logic [CNT_W-1:0] r_count;
        logic             w_sel;
        logic             w_ctrlWr;
        logic             w_presetWr;
        logic             w_load;
        logic             w_dec;
        logic             w_expire;
        logic             w_hwEnClr;
        logic [31:0]      w_presetMerged;

        assign w_sel      = PrWe && Hit && (w_chSel == 3'(k));
        assign w_ctrlWr   = w_sel && (w_wordSel == 2'd0) && PrBE[0];
        assign w_presetWr = w_sel && (w_wordSel == 2'd1);

        always_comb begin
            w_presetMerged = 32'(r_preset);
            for (int b = 0; b < 4; b++) begin
                if (PrBE[b]) begin
                    w_presetMerged[8*b +: 8] = PrWD[8*b +: 8];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= IDLE;
            end else begin
                r_state <= w_stateNext;
            end
        end

        always_comb begin
            w_stateNext = r_state;
            case (r_state)
                IDLE: begin
                    if (r_en) w_stateNext = LOAD;
                end
                LOAD: w_stateNext = CNT;
                CNT: begin
                    if (!r_en) begin
                        w_stateNext = IDLE;
                    end else if (r_count <= CNT_W'(1)) begin
                        w_stateNext = INT;
                    end
                end
                INT: w_stateNext = r_mode ? LOAD : IDLE;
                default: w_stateNext = IDLE;
            endcase
        end

        // A zero preset expires on the first counting cycle, same as a preset of one.
        always_comb begin
            w_load    = (r_state == LOAD);
            w_dec     = (r_state == CNT) && r_en && (r_count > CNT_W'(1));
            w_expire  = (r_state == CNT) && r_en && (r_count <= CNT_W'(1));
            w_hwEnClr = (r_state == INT) && !r_mode;
        end

        // Bus write beats the one-shot EN clear; a new expiry beats a W1C of PEND.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_en     <= 1'b0;
                r_mode   <= 1'b0;
                r_im     <= 1'b0;
                r_pend   <= 1'b0;
                r_preset <= '0;
                r_count  <= '0;
            end else begin
                if (w_ctrlWr) begin
                    r_en   <= PrWD[0];
                    r_mode <= PrWD[1];
                    r_im   <= PrWD[3];
                end else if (w_hwEnClr) begin
                    r_en <= 1'b0;
                end
                if (w_expire) begin
                    r_pend <= 1'b1;
                end else if (w_ctrlWr && PrWD[4]) begin
                    r_pend <= 1'b0;
                end
                if (w_presetWr) begin
                    r_preset <= w_presetMerged[CNT_W-1:0];
                end
                if (w_load) begin
                    r_count <= r_preset;
                end else if (w_expire) begin
                    r_count <= '0;
                end else if (w_dec) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end

        assign IRQ[k]        = r_pend && r_im;
        assign w_rdCtrl[k]   = {27'd0, r_pend, r_im, 1'b0, r_mode, r_en};
        assign w_rdPreset[k] = 32'(r_preset);
        assign w_rdCount[k]  = 32'(r_count);
    end

    always_comb begin
        PrRD = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (Hit && (w_chSel == 3'(k))) begin
                case (w_wordSel)
                    2'd0:    PrRD = w_rdCtrl[k];
                    2'd1:    PrRD = w_rdPreset[k];
                    2'd2:    PrRD = w_rdCount[k];
                    default: PrRD = '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized bus traffic
// compared against a cycle-level behavioural model of the timer channels.
module tb_timer_bank;
    localparam int          NCH    = 3;
    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] BASE16 = 32'h0000_1000;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [31:0]    PrAddr = '0;
    logic [31:0]    PrWD = '0;
    logic           PrWe = 1'b0;
    logic [3:0]     PrBE = '0;
    logic [31:0]    PrRD;
    logic           Hit;
    logic [NCH-1:0] IRQ;

    logic [31:0]    sAddr = BASE16;
    logic [31:0]    sWD = '0;
    logic           sWe = 1'b0;
    logic [3:0]     sBE = '0;
    logic [31:0]    sRD;
    logic           sHit;
    logic [0:0]     sIRQ;

    int vectors = 0;
    int miscompares = 0;

    int          mPhase  [NCH];
    bit          mEn     [NCH];
    bit          mMode   [NCH];
    bit          mIm     [NCH];
    bit          mPend   [NCH];
    logic [31:0] mPreset [NCH];
    logic [31:0] mCount  [NCH];

    timer_bank #(.NUM_CH(NCH), .CNT_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .PrAddr(PrAddr), .PrWD(PrWD), .PrWe(PrWe),
        .PrBE(PrBE), .PrRD(PrRD), .Hit(Hit), .IRQ(IRQ)
    );

    timer_bank #(.NUM_CH(1), .CNT_W(16), .BASE_ADDR(BASE16)) dut16 (
        .clk(clk), .reset(reset), .PrAddr(sAddr), .PrWD(sWD), .PrWe(sWe),
        .PrBE(sBE), .PrRD(sRD), .Hit(sHit), .IRQ(sIRQ)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] chA(input int c, input int o);
        return BASE + 32'(16 * c + o);
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < 32'(16 * NCH);
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] off;
        int c;
        int w;
        off = a - BASE;
        if (off >= 32'(16 * NCH)) return 32'h0;
        c = int'(off >> 4);
        w = int'((off >> 2) & 32'h3);
        case (w)
            0:       return {27'h0, mPend[c], mIm[c], 1'b0, mMode[c], mEn[c]};
            1:       return mPreset[c];
            2:       return mCount[c];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] modelIrq();
        logic [NCH-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c] = mPend[c] & mIm[c];
        return v;
    endfunction

    // Advance the model by one clock edge using the bus inputs currently driven.
    function automatic void modelEdge();
        logic [31:0] off;
        bit hit;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                mPhase[c] = PH_IDLE; mEn[c] = 0; mMode[c] = 0; mIm[c] = 0;
                mPend[c] = 0; mPreset[c] = 0; mCount[c] = 0;
            end
            return;
        end
        off = PrAddr - BASE;
        hit = off < 32'(16 * NCH);
        for (int c = 0; c < NCH; c++) begin
            bit sel;
            bit ctrlWr;
            bit presetWr;
            bit fired;
            sel      = PrWe && hit && (int'(off >> 4) == c);
            ctrlWr   = sel && (((off >> 2) & 32'h3) == 0) && PrBE[0];
            presetWr = sel && (((off >> 2) & 32'h3) == 1);
            fired    = 0;
            case (mPhase[c])
                PH_IDLE: if (mEn[c]) mPhase[c] = PH_LOAD;
                PH_LOAD: begin
                    mCount[c] = mPreset[c];
                    mPhase[c] = PH_CNT;
                end
                PH_CNT: begin
                    if (!mEn[c]) begin
                        mPhase[c] = PH_IDLE;
                    end else if (mCount[c] > 1) begin
                        mCount[c] = mCount[c] - 1;
                    end else begin
                        mCount[c] = 0; mPend[c] = 1; fired = 1; mPhase[c] = PH_INT;
                    end
                end
                default: begin
                    if (mMode[c]) begin
                        mPhase[c] = PH_LOAD;
                    end else begin
                        mEn[c] = 0; mPhase[c] = PH_IDLE;
                    end
                end
            endcase
            if (ctrlWr) begin
                mEn[c] = PrWD[0]; mMode[c] = PrWD[1]; mIm[c] = PrWD[3];
                if (PrWD[4] && !fired) mPend[c] = 0;
            end
            if (presetWr) begin
                for (int b = 0; b < 4; b++) begin
                    if (PrBE[b]) mPreset[c][8*b +: 8] = PrWD[8*b +: 8];
                end
            end
        end
    endfunction

    task automatic step();
        #1;
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        PrAddr = a; PrWD = d; PrBE = be; PrWe = 1'b1;
        step();
        PrWe = 1'b0; PrBE = 4'h0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        PrAddr = a; PrWe = 1'b0;
        #1;
        d = PrRD;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; step(); step(); reset = 1'b0;
        vectors++;
        if (IRQ !== '0) begin miscompares++; $display("[TB] FAIL reset_irq: got %b, expected 0", IRQ); end
        for (int o = 0; o < 16; o += 4) begin
            busRead(chA(0, o), d);
            vectors++;
            if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_reg_%0h: got %h, expected 0", o, d); end
        end
        step();
        busRead(BASE + 32'(16 * NCH), d);
        vectors++;
        if (Hit !== 1'b0 || d !== 32'h0) begin
            miscompares++; $display("[TB] FAIL miss_above: Hit=%b PrRD=%h, expected Hit=0 PrRD=0", Hit, d);
        end
        busRead(BASE - 32'd4, d);
        vectors++;
        if (Hit !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_below: Hit=%b, expected 0", Hit); end
        busRead(BASE + 32'(16 * NCH - 1), d);
        vectors++;
        if (Hit !== 1'b1 || d !== 32'h0) begin
            miscompares++; $display("[TB] FAIL hit_last: Hit=%b PrRD=%h, expected Hit=1 PrRD=0", Hit, d);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        int edges;
        busWrite(chA(0, 4), 32'd5, 4'hF);
        busWrite(chA(0, 0), 32'h9, 4'hF);
        edges = 0;
        while (IRQ[0] !== 1'b1 && edges < 20) begin
            step();
            edges++;
            if (edges == 2 || edges == 6) begin
                busRead(chA(0, 8), d);
                vectors++;
                if (d !== ((edges == 2) ? 32'd5 : 32'd1)) begin
                    miscompares++; $display("[TB] FAIL oneshot_count_e%0d: got %0d", edges, d);
                end
            end
        end
        vectors++;
        if (edges != 7) begin miscompares++; $display("[TB] FAIL oneshot_latency: got %0d edges, expected 7", edges); end
        step();
        busRead(chA(0, 8), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL oneshot_count_end: got %h, expected 0", d); end
        busRead(chA(0, 0), d);
        vectors++;
        if (d !== 32'h18) begin miscompares++; $display("[TB] FAIL oneshot_ctrl: got %h, expected 18", d); end
        busWrite(chA(0, 0), 32'h10, 4'h1);
        vectors++;
        if (IRQ[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL oneshot_w1c: IRQ0=%b, expected 0", IRQ[0]); end
    endtask

    task automatic test_autoreload();
        int rises;
        int lastRise;
        bit prev;
        bit sawIrq0;
        int expected;
        busWrite(chA(1, 4), 32'd3, 4'hF);
        busWrite(chA(1, 0), 32'hB, 4'hF);
        rises = 0; lastRise = 0; prev = 0; sawIrq0 = 0;
        for (int e = 1; e <= 30; e++) begin
            if (IRQ[1] === 1'b1) begin
                PrAddr = chA(1, 0); PrWD = 32'h1B; PrBE = 4'h1; PrWe = 1'b1;
            end
            step();
            PrWe = 1'b0;
            if (IRQ[0] !== 1'b0) sawIrq0 = 1;
            if (IRQ[1] === 1'b1 && !prev) begin
                expected = (rises == 0) ? 5 : lastRise + 5;
                vectors++;
                if (e != expected) begin
                    miscompares++; $display("[TB] FAIL reload_period: rise at edge %0d, expected %0d", e, expected);
                end
                rises++;
                lastRise = e;
            end
            prev = (IRQ[1] === 1'b1);
        end
        vectors++;
        if (rises != 6) begin miscompares++; $display("[TB] FAIL reload_rises: got %0d, expected 6", rises); end
        vectors++;
        if (sawIrq0) begin miscompares++; $display("[TB] FAIL idle_ch0_irq: got 1, expected 0"); end
        busWrite(chA(1, 0), 32'h10, 4'h1);
        step(); step(); step();
        vectors++;
        if (IRQ[1] !== 1'b0) begin miscompares++; $display("[TB] FAIL reload_stop: IRQ1=%b, expected 0", IRQ[1]); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        busWrite(chA(2, 4), 32'hAABBCCDD, 4'b0011);
        busRead(chA(2, 4), d);
        vectors++;
        if (d !== 32'h0000CCDD) begin miscompares++; $display("[TB] FAIL be_low: got %h, expected 0000ccdd", d); end
        busWrite(chA(2, 4), 32'h11223344, 4'b0100);
        busRead(chA(2, 4), d);
        vectors++;
        if (d !== 32'h0022CCDD) begin miscompares++; $display("[TB] FAIL be_byte2: got %h, expected 0022ccdd", d); end
        busWrite(chA(2, 8), 32'hFFFFFFFF, 4'hF);
        busRead(chA(2, 8), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL count_ro: got %h, expected 0", d); end
        busWrite(chA(2, 12), 32'hFFFFFFFF, 4'hF);
        busRead(chA(2, 12), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL reserved: got %h, expected 0", d); end
        busWrite(chA(2, 0), 32'h1, 4'b1110);
        busRead(chA(2, 0), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL ctrl_be0_off: got %h, expected 0", d); end
        sAddr = BASE16 + 32'd4; sWD = 32'h12345678; sBE = 4'hF; sWe = 1'b1;
        step();
        sWe = 1'b0;
        vectors++;
        if (sHit !== 1'b1 || sRD !== 32'h00005678) begin
            miscompares++; $display("[TB] FAIL width16: Hit=%b PrRD=%h, expected Hit=1 PrRD=00005678", sHit, sRD);
        end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        busWrite(chA(0, 4), 32'd2, 4'hF);
        busWrite(chA(0, 0), 32'h9, 4'hF);
        step(); step(); step();
        vectors++;
        if (IRQ[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL w1c_pre: IRQ0=%b, expected 0", IRQ[0]); end
        busWrite(chA(0, 0), 32'h19, 4'h1);
        vectors++;
        if (IRQ[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL w1c_collide_irq: IRQ0=%b, expected 1", IRQ[0]); end
        busRead(chA(0, 0), d);
        vectors++;
        if (d !== 32'h19) begin miscompares++; $display("[TB] FAIL w1c_collide_ctrl: got %h, expected 19", d); end
        busWrite(chA(0, 0), 32'h18, 4'h1);
        vectors++;
        if (IRQ[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL w1c_second: IRQ0=%b, expected 0", IRQ[0]); end
        busRead(chA(0, 0), d);
        vectors++;
        if (d !== 32'h08) begin miscompares++; $display("[TB] FAIL w1c_second_ctrl: got %h, expected 08", d); end
        // Rewrite EN on the INT edge: the bus keeps EN set and the channel restarts.
        busWrite(chA(0, 0), 32'h9, 4'hF);
        step(); step(); step(); step();
        vectors++;
        if (IRQ[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL en_race_expiry: IRQ0=%b, expected 1", IRQ[0]); end
        busWrite(chA(0, 0), 32'h19, 4'h1);
        busRead(chA(0, 0), d);
        vectors++;
        if (d !== 32'h09) begin miscompares++; $display("[TB] FAIL en_race_ctrl: got %h, expected 09", d); end
        step(); step(); step();
        vectors++;
        if (IRQ[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL en_race_early: IRQ0=%b, expected 0", IRQ[0]); end
        step();
        vectors++;
        if (IRQ[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL en_race_restart: IRQ0=%b, expected 1", IRQ[0]); end
        busWrite(chA(0, 0), 32'h10, 4'h1);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        bit sawIrq;
        busWrite(chA(0, 4), 32'd100, 4'hF);
        busWrite(chA(0, 0), 32'h9, 4'hF);
        step(); step();
        busRead(chA(0, 8), d);
        vectors++;
        if (d !== 32'd100) begin miscompares++; $display("[TB] FAIL midcount_pre: got %0d, expected 100", d); end
        reset = 1'b1; step(); reset = 1'b0;
        busRead(chA(0, 8), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL midcount_count: got %h, expected 0", d); end
        busRead(chA(0, 0), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL midcount_ctrl: got %h, expected 0", d); end
        sawIrq = 0;
        for (int i = 0; i < 110; i++) begin
            step();
            if (IRQ !== '0) sawIrq = 1;
        end
        vectors++;
        if (sawIrq) begin miscompares++; $display("[TB] FAIL midcount_irq: got 1, expected 0"); end
        busRead(chA(0, 8), d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("[TB] FAIL midcount_idle: got %h, expected 0", d); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [NCH-1:0] expIrq;
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            int op;
            int ch;
            int wsel;
            op   = $urandom_range(0, 19);
            ch   = $urandom_range(0, NCH);
            wsel = $urandom_range(0, 3);
            a    = BASE + 32'(16 * ch + 4 * wsel + $urandom_range(0, 3));
            if (op == 19) a = BASE - 32'($urandom_range(1, 64));
            PrWe = 1'b0; PrBE = 4'hF; PrWD = $urandom;
            if (op >= 8 && op < 12) begin
                a = BASE + 32'(16 * ch);
                PrWD = 32'($urandom_range(0, 31));
                PrWe = 1'b1;
                if ($urandom_range(0, 5) == 0) PrBE = 4'($urandom);
            end else if (op >= 12 && op < 15) begin
                a = BASE + 32'(16 * ch + 4);
                PrWD = 32'($urandom_range(0, 7));
                PrWe = 1'b1;
                if ($urandom_range(0, 4) == 0) PrBE = 4'($urandom);
            end else if (op >= 15 && op < 18) begin
                PrWe = 1'b1;
                PrBE = 4'($urandom);
            end
            PrAddr = a;
            reset = ($urandom_range(0, 299) == 0);
            #1;
            vectors++;
            if (Hit !== modelHit(a) || PrRD !== modelRead(a)) begin
                miscompares++;
                $display("[TB] FAIL rand_read @%0d addr %h: Hit=%b PrRD=%h, expected Hit=%b PrRD=%h",
                         i, a, Hit, PrRD, modelHit(a), modelRead(a));
            end
            step();
            PrWe = 1'b0; reset = 1'b0;
            expIrq = modelIrq();
            vectors++;
            if (IRQ !== expIrq) begin
                miscompares++; $display("[TB] FAIL rand_irq @%0d: got %b, expected %b", i, IRQ, expIrq);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_byte_enable();
        test_w1c_collision();
        test_reset_midcount();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
